// File: rtl/com_parse_pkg.sv
// Shared constants and state encoding for the collect-link command parser.
package com_parse_pkg;

  localparam logic [7:0]  HDR0        = 8'h55;
  localparam logic [7:0]  HDR1        = 8'hAA;
  localparam int unsigned PAYLOAD_LEN = 7;
  localparam logic [7:0]  ERR_MAX     = 8'hFF;

  typedef enum logic [2:0] {
    HEAD0,
    HEAD1,
    TYPE,
    DATA,
    CSUM,
    DONE,
    LAST
  } state_t;

endpackage

// File: rtl/com_parse_tmo.sv
// Inter-byte timeout counter: expire pulses when TIMEOUT enabled cycles elapse without a clear.
module com_parse_tmo #(
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  logic [15:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 16'd1;
    end
  end

  assign expire = en && (cnt == 16'(TIMEOUT - 1));

endmodule

// File: rtl/com_cmd_parse.sv
// Receive-side command parser for the collect link; frames, checks and hands off commands.
// Define COM_CMD_CHECKSUM_EN to add the trailing XOR checksum byte (11-byte frame instead of 10).
module com_cmd_parse
  import com_parse_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rxd_data,
  input  logic        rxd_vld,
  output logic        fs_com_read,
  input  logic        fd_com_read,
  output logic [3:0]  com_btype,
  output logic [51:0] cache_cmd,
  output logic [7:0]  err_cnt
);

`ifdef COM_CMD_CHECKSUM_EN
  localparam int unsigned SH_W = 52;
`else
  localparam int unsigned SH_W = 44;
`endif

  state_t            state, next_state;
  logic [2:0]        idx;
  logic [SH_W-1:0]   shreg;
  logic [3:0]        btype_buf;
  logic [51:0]       load_cmd;
  logic              frame_err;
  logic              load;
  logic              timed;
  logic              tmo_en;
  logic              tmo_clr;
  logic              expire;
  logic              last_byte;
`ifdef COM_CMD_CHECKSUM_EN
  logic [7:0]        csum;
`endif

  assign timed     = (state == TYPE) || (state == DATA) || (state == CSUM);
  assign tmo_en    = timed && !rxd_vld;
  assign tmo_clr   = rxd_vld || (next_state != state);
  assign last_byte = (idx == 3'(PAYLOAD_LEN - 1));

  // Without a checksum byte the final payload byte is still on rxd_data when loading.
`ifdef COM_CMD_CHECKSUM_EN
  assign load_cmd = shreg;
`else
  assign load_cmd = {shreg, rxd_data};
`endif

  com_parse_tmo #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk    (clk),
    .rst    (rst),
    .clr    (tmo_clr),
    .en     (tmo_en),
    .expire (expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= HEAD0;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    frame_err  = 1'b0;
    load       = 1'b0;
    unique case (state)
      HEAD0: begin
        if (rxd_vld && rxd_data == HDR0) next_state = HEAD1;
      end
      HEAD1: begin
        if (rxd_vld) begin
          if (rxd_data == HDR1)      next_state = TYPE;
          else if (rxd_data != HDR0) next_state = HEAD0;
        end
      end
      TYPE: begin
        if (rxd_vld) begin
          if (rxd_data[7:4] != 4'h0) begin
            frame_err  = 1'b1;
            next_state = HEAD0;
          end else begin
            next_state = DATA;
          end
        end else if (expire) begin
          frame_err  = 1'b1;
          next_state = HEAD0;
        end
      end
      DATA: begin
        if (rxd_vld) begin
          if (idx == 3'd0 && rxd_data[7:4] != 4'h0) begin
            frame_err  = 1'b1;
            next_state = HEAD0;
          end else if (last_byte) begin
`ifdef COM_CMD_CHECKSUM_EN
            next_state = CSUM;
`else
            next_state = DONE;
            load       = 1'b1;
`endif
          end
        end else if (expire) begin
          frame_err  = 1'b1;
          next_state = HEAD0;
        end
      end
`ifdef COM_CMD_CHECKSUM_EN
      CSUM: begin
        if (rxd_vld) begin
          if (rxd_data == csum) begin
            next_state = DONE;
            load       = 1'b1;
          end else begin
            frame_err  = 1'b1;
            next_state = HEAD0;
          end
        end else if (expire) begin
          frame_err  = 1'b1;
          next_state = HEAD0;
        end
      end
`endif
      DONE: begin
        frame_err = rxd_vld;
        if (fd_com_read) next_state = LAST;
      end
      LAST: begin
        frame_err = rxd_vld;
        if (!fd_com_read) next_state = HEAD0;
      end
      default: next_state = HEAD0;
    endcase
  end

  always_comb begin
    fs_com_read = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx       <= '0;
      shreg     <= '0;
      btype_buf <= '0;
      com_btype <= '0;
      cache_cmd <= '0;
      err_cnt   <= '0;
`ifdef COM_CMD_CHECKSUM_EN
      csum      <= '0;
`endif
    end else begin
      if (rxd_vld && state == TYPE) begin
        idx       <= '0;
        btype_buf <= rxd_data[3:0];
`ifdef COM_CMD_CHECKSUM_EN
        csum      <= rxd_data;
`endif
      end
      if (rxd_vld && state == DATA) begin
        shreg <= SH_W'({shreg, rxd_data});
        idx   <= idx + 3'd1;
`ifdef COM_CMD_CHECKSUM_EN
        csum  <= csum ^ rxd_data;
`endif
      end
      if (load) begin
        cache_cmd <= load_cmd;
        com_btype <= btype_buf;
      end
      if (frame_err && err_cnt != ERR_MAX) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_com_cmd_parse.sv
// Randomized self-checking bench for com_cmd_parse using a frame-level reference model.
module tb_com_cmd_parse;

  localparam int unsigned TMO = 24;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rxd_data;
  logic        rxd_vld;
  logic        fs_com_read;
  logic        fd_com_read;
  logic [3:0]  com_btype;
  logic [51:0] cache_cmd;
  logic [7:0]  err_cnt;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  logic [3:0]  exp_btype;
  logic [51:0] exp_cmd;
  int unsigned exp_err;

  com_cmd_parse #(.TIMEOUT(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .rxd_data    (rxd_data),
    .rxd_vld     (rxd_vld),
    .fs_com_read (fs_com_read),
    .fd_com_read (fd_com_read),
    .com_btype   (com_btype),
    .cache_cmd   (cache_cmd),
    .err_cnt     (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rxd_data = b;
    rxd_vld  = 1'b1;
    tick();
    rxd_vld  = 1'b0;
  endtask

  function automatic int unsigned sat_inc(input int unsigned v);
    return (v >= 255) ? 255 : v + 1;
  endfunction

  function automatic logic [7:0] pbyte(input logic [55:0] pl, input int i);
    return pl[55-8*i -: 8];
  endfunction

  function automatic logic [51:0] cmd_of(input logic [55:0] pl);
    logic [63:0] v = 0;
    for (int i = 0; i < 7; i++) v = v * 256 + 64'(pbyte(pl, i));
    return v[51:0];
  endfunction

  function automatic logic [7:0] csum_of(input logic [7:0] b, input logic [55:0] pl);
    logic [7:0] c = b;
    for (int i = 0; i < 7; i++) c = c ^ pbyte(pl, i);
    return c;
  endfunction

  function automatic logic [55:0] rand_pl();
    logic [63:0] r = {$urandom, $urandom};
    return {4'h0, r[51:0]};
  endfunction

  task automatic gap(input int unsigned lo, input int unsigned hi);
    repeat ($urandom_range(hi, lo)) tick();
  endtask

  task automatic send_body(input logic [7:0] b, input logic [55:0] pl,
                           input int unsigned glo, input int unsigned ghi);
    gap(glo, ghi);
    send_byte(b);
    for (int i = 0; i < 7; i++) begin
      gap(glo, ghi);
      send_byte(pbyte(pl, i));
    end
  endtask

  task automatic check_outputs(input string tag, input logic fs_exp);
    check_val({tag, "_fs"}, 64'(fs_com_read), 64'(fs_exp));
    check_val({tag, "_btype"}, 64'(com_btype), 64'(exp_btype));
    check_val({tag, "_cmd"}, 64'(cache_cmd), 64'(exp_cmd));
    check_val({tag, "_err"}, 64'(err_cnt), 64'(exp_err));
  endtask

  task automatic handshake(input string tag, input int unsigned delay);
    for (int i = 0; i < int'(delay); i++) begin
      check_val({tag, "_fs_hold"}, 64'(fs_com_read), 64'd1);
      tick();
    end
    fd_com_read = 1'b1;
    tick();
    check_val({tag, "_fs_fall"}, 64'(fs_com_read), 64'd0);
    check_val({tag, "_cmd_last"}, 64'(cache_cmd), 64'(exp_cmd));
    fd_com_read = 1'b0;
    tick();
  endtask

  // Sends an optional noise prefix, header, body (and checksum), then checks the decode.
  task automatic good_frame(input string tag, input logic [7:0] b, input logic [55:0] pl,
                            input int unsigned glo, input int unsigned ghi,
                            input int unsigned noise, input logic do_hs, input int unsigned fdd);
    for (int i = 0; i < int'(noise); i++) send_byte(8'($urandom));
    send_byte(8'h55);
    send_byte(8'hAA);
    send_body(b, pl, glo, ghi);
`ifdef COM_CMD_CHECKSUM_EN
    gap(glo, ghi);
    send_byte(csum_of(b, pl));
`endif
    exp_btype = b[3:0];
    exp_cmd   = cmd_of(pl);
    check_outputs(tag, 1'b1);
    if (do_hs) handshake(tag, fdd);
  endtask

  initial begin
    logic [55:0] pl;
    logic [7:0]  b;
    rst = 1'b1; rxd_vld = 1'b0; rxd_data = '0; fd_com_read = 1'b0;
    exp_btype = '0; exp_cmd = '0; exp_err = 0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check_outputs("reset", 1'b0);

    pl = 56'h01_12_34_56_78_9A_BC;
    good_frame("directed", 8'h03, pl, 0, 0, 0, 1'b1, 3);
    check_val("directed_cmd_val", 64'(cache_cmd), 64'h1_1234_5678_9ABC);

`ifdef COM_CMD_CHECKSUM_EN
    send_byte(8'h55); send_byte(8'hAA);
    send_body(8'h07, rand_pl(), 0, 2);
    send_byte(csum_of(8'h07, pl) ^ 8'h01 ^ 8'hFF);
    exp_err = sat_inc(exp_err);
    check_outputs("bad_csum", 1'b0);
    good_frame("after_csum", 8'h09, rand_pl(), 0, 2, 0, 1'b1, 1);
`endif

    send_byte(8'h55); send_byte(8'hAA); send_byte(8'h23);
    exp_err = sat_inc(exp_err);
    check_outputs("bad_type", 1'b0);

    send_byte(8'h55); send_byte(8'hAA); send_byte(8'h02); send_byte(8'h10);
    exp_err = sat_inc(exp_err);
    check_outputs("bad_p0", 1'b0);

    send_byte(8'h55);
    good_frame("resync", 8'h0C, rand_pl(), 0, 0, 0, 1'b1, 0);

    send_byte(8'h55); send_byte(8'hAA); send_byte(8'h05);
    send_byte(8'h0A); send_byte(8'h11); send_byte(8'h22);
    repeat (TMO - 1) tick();
    check_val("tmo_edge_err", 64'(err_cnt), 64'(exp_err));
    tick();
    exp_err = sat_inc(exp_err);
    check_outputs("tmo", 1'b0);
    good_frame("after_tmo", 8'h0E, rand_pl(), 0, 1, 0, 1'b1, 2);

    good_frame("gap_max", 8'h01, rand_pl(), TMO - 1, TMO - 1, 0, 1'b1, 0);

    good_frame("overrun", 8'h04, rand_pl(), 0, 0, 0, 1'b0, 0);
    send_byte(8'h55);
    send_byte(8'h3C);
    exp_err = sat_inc(sat_inc(exp_err));
    check_outputs("overrun", 1'b1);
    handshake("overrun", 0);

    for (int n = 0; n < 40; n++) begin
      b = {4'h0, 4'($urandom)};
      good_frame("rand", b, rand_pl(), 0, 3, $urandom_range(3, 0), 1'b1, $urandom_range(4, 0));
    end

    send_byte(8'h55); send_byte(8'hAA); send_byte(8'h06); send_byte(8'h03);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_btype = '0; exp_cmd = '0; exp_err = 0;
    check_outputs("rst_mid", 1'b0);

    for (int n = 0; n < 260; n++) begin
      send_byte(8'h55); send_byte(8'hAA);
      send_byte({4'($urandom_range(15, 1)), 4'($urandom)});
      exp_err = sat_inc(exp_err);
    end
    check_outputs("sat", 1'b0);
    send_byte(8'h55); send_byte(8'hAA); send_byte(8'hF0);
    exp_err = sat_inc(exp_err);
    check_val("sat_hold", 64'(err_cnt), 64'(exp_err));
    good_frame("after_sat", 8'h0B, rand_pl(), 0, 2, 1, 1'b1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
